piece_writer: RTL and testbench
===============================

// Module: piece_writer
// PURPOSE
//  Write side of the board-cell memory. On a piece lock (or erase), walks the
//  piece's 4x4 shape mask and issues one board write per occupied,
//  in-bounds cell.
//  Sits between the game-control FSM and the board RAM write port. It is the
//  counterpart of the collision scanner, which reads the same cells.
//  Fixed-latency, start/done handshake, one cell examined per clock.
// PARAMETERS
//  BOARD_W  10  board width in cells; valid wr_x range 0..BOARD_W-1
//  BOARD_H  20  board height in cells; valid wr_y range 0..BOARD_H-1
// PORTS
//  clk       in   1   system clock, all state on posedge
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   1-cycle request; sampled only in IDLE
//  x         in   5   piece box origin column (top-left of 4x4 box)
//  y         in   5   piece box origin row (row 0 = top)
//  mask      in   16  shape; bit r*4+c = cell (row r, col c) occupied
//  color     in   3   cell id to write; 0 = empty (erase pass)
//  busy      out  1   high from cycle after accepted start through done cycle
//  done      out  1   1-cycle pulse, last cycle of operation
//  wr_en     out  1   board write strobe, one cell per asserted cycle
//  wr_x      out  5   write column
//  wr_y      out  5   write row
//  wr_data   out  3   write cell id (= latched color)
//  n_written out  5   cells written in the last operation; held until next start
//  clipped   out  1   last operation skipped >=1 occupied out-of-bounds cell; held
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. busy, done, wr_en and clipped are 0.
//   wr_x, wr_y, wr_data and n_written are 0. The latched x/y/mask/color and idx are cleared.
//   Reset mid-operation aborts immediately; wr_en drops without waiting for clk.
//   Cells already written stay written.
//  States: IDLE -> SCAN -> DONE -> IDLE.
//  IDLE: on start=1, latch x, y, mask and color. Set idx=0. Clear n_written and clipped.
//   Go to SCAN. start while busy is ignored; inputs are not re-latched.
//  SCAN: idx 0..15, one per cycle. Examine cell r=idx[3:2], c=idx[1:0].
//   Compute sums 6 bits wide: sx = x+c, sy = y+r.
//   Occupied and sx<BOARD_W and sy<BOARD_H: wr_en=1, wr_x=sx[4:0], wr_y=sy[4:0],
//    wr_data=color; n_written++ at the end of that cycle.
//   Occupied but out of bounds: wr_en=0, clipped<=1.
//   Unoccupied: wr_en=0.
//   wr_en is registered. The write for idx k appears in SCAN cycle k, with
//    addresses valid in the same cycle.
//   After idx 15 go to DONE. There is no early exit on an empty mask; latency is constant.
//  DONE: done=1 and busy=1 for one cycle, wr_en=0, then IDLE.
//  Latency: start sampled at edge 0 -> 16 SCAN cycles -> done high in cycle 17.
//   Next start is accepted the cycle after done.
//  wr_x/wr_y/wr_data hold their last values when wr_en=0 (don't-care for the RAM).
//  Writes are issued strictly in ascending idx order, i.e. row-major, top-left first.
//  color=0 is legal and erases the piece footprint. Its cell count and clip rules are the same.
// TESTING
//  T-piece x=3 y=0 mask=16'h0072 color=5 -> writes (4,0),(3,1),(4,1),(5,1) in that order.
//   Expect n_written=4, clipped=0, done in cycle 17.
//  I-piece x=8 y=5 mask=16'h000F -> writes (8,5),(9,5) only; cols 10 and 11 skipped.
//   Expect n_written=2, clipped=1.
//  O-piece x=0 y=19 mask=16'h0033 color=2 -> writes (0,19),(1,19) only; row 20 skipped.
//   Expect n_written=2, clipped=1.
//  mask=16'h0000 -> no wr_en for 16 cycles; done in cycle 17; n_written=0, clipped=0.
//  start re-pulsed at cycle 5 with different x -> ignored; original writes complete unchanged.
//  reset_n low during SCAN at idx 6 -> wr_en, busy and done are 0 immediately.
//   Outputs are at reset values; a fresh start then runs the full 17 cycles.

Source files
------------

// File: rtl/piece_writer_if.sv
// Piece-writer bus: request side from the game-control FSM plus the board RAM
// write port and the per-operation status flags.
//   start/x/y/mask/color : lock/erase request (driven by the controller)
//   busy/done            : operation status
//   wr_en/wr_x/wr_y/wr_data : board RAM write port
//   n_written/clipped    : result of the last operation, held until next start
interface piece_writer_if;
  logic        start;
  logic [4:0]  x;
  logic [4:0]  y;
  logic [15:0] mask;
  logic [2:0]  color;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_x;
  logic [4:0]  wr_y;
  logic [2:0]  wr_data;
  logic [4:0]  n_written;
  logic        clipped;

  modport master (
    output start, x, y, mask, color,
    input  busy, done, wr_en, wr_x, wr_y, wr_data, n_written, clipped
  );

  modport slave (
    input  start, x, y, mask, color,
    output busy, done, wr_en, wr_x, wr_y, wr_data, n_written, clipped
  );
endinterface

// File: rtl/piece_writer.sv
// Board-cell write walker. On an accepted start, walks the 4x4 piece mask in
// row-major order, one cell per clock, and issues one board write per
// occupied in-bounds cell. Out-of-bounds occupied cells are skipped and flagged.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : piece_writer_if.slave (request, write port, status)
module piece_writer #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  piece_writer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [15:0] mask_q, mask_d;
  logic [2:0]  color_q, color_d;
  logic [3:0]  idx_q, idx_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_x_q, wr_x_d;
  logic [4:0]  wr_y_q, wr_y_d;
  logic [2:0]  wr_data_q, wr_data_d;
  logic [4:0]  n_written_q, n_written_d;
  logic        clipped_q, clipped_d;

  // The write strobe is registered, so each cell is examined one edge ahead of
  // the cycle in which its write appears. From IDLE the first cell comes
  // straight from the request inputs; afterwards from the latched copy.
  logic        ex_from_bus;
  logic [4:0]  ex_x, ex_y;
  logic [15:0] ex_mask;
  logic [2:0]  ex_color;
  logic [3:0]  ex_idx;
  logic [5:0]  sx, sy;
  logic        ex_occ, ex_inb, examine;

  assign ex_from_bus = (state_q == StIdle);
  assign ex_x        = ex_from_bus ? bus.x     : x_q;
  assign ex_y        = ex_from_bus ? bus.y     : y_q;
  assign ex_mask     = ex_from_bus ? bus.mask  : mask_q;
  assign ex_color    = ex_from_bus ? bus.color : color_q;
  assign ex_idx      = ex_from_bus ? 4'd0      : idx_q + 4'd1;

  // 6-bit sums so a box hanging past column/row 31 cannot wrap back in bounds.
  assign sx     = {1'b0, ex_x} + {4'b0, ex_idx[1:0]};
  assign sy     = {1'b0, ex_y} + {4'b0, ex_idx[3:2]};
  assign ex_occ = ex_mask[ex_idx];
  assign ex_inb = (sx < 6'(BOARD_W)) && (sy < 6'(BOARD_H));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mask_d      = mask_q;
    color_d     = color_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_data_d   = wr_data_q;
    n_written_d = n_written_q;
    clipped_d   = clipped_q;
    examine     = 1'b0;

    // Count the write that is on the port during this cycle.
    if (wr_en_q) n_written_d = n_written_q + 5'd1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d         = bus.x;
          y_d         = bus.y;
          mask_d      = bus.mask;
          color_d     = bus.color;
          idx_d       = 4'd0;
          n_written_d = 5'd0;
          clipped_d   = 1'b0;
          examine     = 1'b1;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (idx_q == 4'd15) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 4'd1;
          examine = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Address/data only move on a real write; they hold otherwise.
    if (examine && ex_occ) begin
      if (ex_inb) begin
        wr_en_d   = 1'b1;
        wr_x_d    = sx[4:0];
        wr_y_d    = sy[4:0];
        wr_data_d = ex_color;
      end else begin
        clipped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      x_q         <= 5'd0;
      y_q         <= 5'd0;
      mask_q      <= 16'd0;
      color_q     <= 3'd0;
      idx_q       <= 4'd0;
      wr_en_q     <= 1'b0;
      wr_x_q      <= 5'd0;
      wr_y_q      <= 5'd0;
      wr_data_q   <= 3'd0;
      n_written_q <= 5'd0;
      clipped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mask_q      <= mask_d;
      color_q     <= color_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_data_q   <= wr_data_d;
      n_written_q <= n_written_d;
      clipped_q   <= clipped_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.n_written = n_written_q;
  assign bus.clipped   = clipped_q;

endmodule

// File: tb/tb_piece_writer.sv
// Directed bench for piece_writer: each scenario task drives one operation and
// compares the captured write stream and status against hand-derived values.
module tb_piece_writer;
  logic clk;
  logic reset_n;

  piece_writer_if bus ();

  piece_writer #(
    .BOARD_W(10),
    .BOARD_H(20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Capture of one operation; cycle 1 is the cycle after the accepting edge.
  int cap_x[16];
  int cap_y[16];
  int cap_d[16];
  int cap_c[16];
  int cap_n;
  int done_cyc;
  logic busy1;

  task automatic run_op(input logic [4:0] px, input logic [4:0] py, input logic [15:0] pm,
                        input logic [2:0] pc, input int repulse);
    cap_n    = 0;
    done_cyc = -1;
    busy1    = 1'b0;
    @(negedge clk);
    bus.x     = px;
    bus.y     = py;
    bus.mask  = pm;
    bus.color = pc;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = bus.busy;
      if (bus.wr_en) begin
        if (cap_n < 16) begin
          cap_x[cap_n] = int'(bus.wr_x);
          cap_y[cap_n] = int'(bus.wr_y);
          cap_d[cap_n] = int'(bus.wr_data);
          cap_c[cap_n] = c;
        end
        cap_n++;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (c == repulse) begin
        bus.start = 1'b1;
        bus.x     = 5'd0;
        bus.mask  = 16'hFFFF;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.busy, bus.done, bus.wr_en, bus.clipped} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.busy, bus.done, bus.wr_en, bus.clipped});
    end
    n_cmp++;
    if ({bus.wr_x, bus.wr_y, bus.wr_data, bus.n_written} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {bus.wr_x, bus.wr_y, bus.wr_data, bus.n_written});
    end
  endtask

  // T-piece: (4,0),(3,1),(4,1),(5,1) for idx 1,4,5,6 -> cycles 2,5,6,7.
  task automatic check_t_piece(input string tag, input int col, input int repulse);
    int ex_x[4] = '{4, 3, 4, 5};
    int ex_y[4] = '{0, 1, 1, 1};
    int ex_c[4] = '{2, 5, 6, 7};
    run_op(5'd3, 5'd0, 16'h0072, 3'(col), repulse);
    n_cmp++;
    if (cap_n !== 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d want 4", tag, cap_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_x[i] !== ex_x[i] || cap_y[i] !== ex_y[i] || cap_d[i] !== col ||
          cap_c[i] !== ex_c[i]) begin
        n_fail++;
        $display("FAIL %s_wr%0d: got (%0d,%0d) d=%0d cyc=%0d want (%0d,%0d) d=%0d cyc=%0d",
                 tag, i, cap_x[i], cap_y[i], cap_d[i], cap_c[i], ex_x[i], ex_y[i], col, ex_c[i]);
      end
    end
    n_cmp++;
    if (done_cyc !== 17) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got %0d want 17", tag, done_cyc);
    end
    n_cmp++;
    if (bus.n_written !== 5'd4 || bus.clipped !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_status: got n=%0d clip=%b busy=%b want n=4 clip=0 busy=1",
               tag, bus.n_written, bus.clipped, bus.busy);
    end
  endtask

  task automatic test_t_piece();
    check_t_piece("t_piece", 5, 0);
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL t_busy_cycle1: got %b want 1", busy1);
    end
  endtask

  task automatic test_erase();
    check_t_piece("erase", 0, 0);
  endtask

  task automatic test_restart_ignored();
    check_t_piece("restart", 5, 5);
  endtask

  task automatic test_clip_right();
    run_op(5'd8, 5'd5, 16'h000F, 3'd6, 0);
    n_cmp++;
    if (cap_n !== 2 || cap_x[0] !== 8 || cap_y[0] !== 5 || cap_x[1] !== 9 || cap_y[1] !== 5 ||
        cap_d[0] !== 6) begin
      n_fail++;
      $display("FAIL i_writes: got n=%0d (%0d,%0d) (%0d,%0d) d=%0d want n=2 (8,5) (9,5) d=6",
               cap_n, cap_x[0], cap_y[0], cap_x[1], cap_y[1], cap_d[0]);
    end
    n_cmp++;
    if (bus.n_written !== 5'd2 || bus.clipped !== 1'b1 || done_cyc !== 17) begin
      n_fail++;
      $display("FAIL i_status: got n=%0d clip=%b done=%0d want n=2 clip=1 done=17",
               bus.n_written, bus.clipped, done_cyc);
    end
  endtask

  task automatic test_clip_bottom();
    run_op(5'd0, 5'd19, 16'h0033, 3'd2, 0);
    n_cmp++;
    if (cap_n !== 2 || cap_x[0] !== 0 || cap_y[0] !== 19 || cap_x[1] !== 1 ||
        cap_y[1] !== 19 || cap_d[1] !== 2 || cap_c[0] !== 1 || cap_c[1] !== 2) begin
      n_fail++;
      $display("FAIL o_writes: got n=%0d (%0d,%0d)@%0d (%0d,%0d)@%0d want n=2 (0,19)@1 (1,19)@2",
               cap_n, cap_x[0], cap_y[0], cap_c[0], cap_x[1], cap_y[1], cap_c[1]);
    end
    n_cmp++;
    if (bus.n_written !== 5'd2 || bus.clipped !== 1'b1) begin
      n_fail++;
      $display("FAIL o_status: got n=%0d clip=%b want n=2 clip=1", bus.n_written, bus.clipped);
    end
  endtask

  task automatic test_empty_mask();
    run_op(5'd4, 5'd4, 16'h0000, 3'd3, 0);
    n_cmp++;
    if (cap_n !== 0 || done_cyc !== 17) begin
      n_fail++;
      $display("FAIL empty_run: got writes=%0d done=%0d want writes=0 done=17", cap_n, done_cyc);
    end
    n_cmp++;
    if (bus.n_written !== 5'd0 || bus.clipped !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_status: got n=%0d clip=%b want n=0 clip=0",
               bus.n_written, bus.clipped);
    end
    // Stale write address from the previous operation is held.
    n_cmp++;
    if (bus.wr_x !== 5'd1 || bus.wr_y !== 5'd19) begin
      n_fail++;
      $display("FAIL empty_hold_addr: got (%0d,%0d) want (1,19)", bus.wr_x, bus.wr_y);
    end
  endtask

  task automatic test_back_to_back();
    run_op(5'd8, 5'd5, 16'h000F, 3'd1, 0);
    run_op(5'd0, 5'd0, 16'h8001, 3'd4, 0);
    n_cmp++;
    if (busy1 !== 1'b1 || done_cyc !== 17 || cap_n !== 2 || cap_x[1] !== 3 || cap_y[1] !== 3 ||
        cap_c[1] !== 16) begin
      n_fail++;
      $display("FAIL b2b: got busy1=%b done=%0d n=%0d last=(%0d,%0d)@%0d want 1 17 2 (3,3)@16",
               busy1, done_cyc, cap_n, cap_x[1], cap_y[1], cap_c[1]);
    end
    n_cmp++;
    if (bus.n_written !== 5'd2 || bus.clipped !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_status: got n=%0d clip=%b want n=2 clip=0",
               bus.n_written, bus.clipped);
    end
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    bus.x     = 5'd3;
    bus.y     = 5'd0;
    bus.mask  = 16'h0072;
    bus.color = 3'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_x !== 5'd5 || bus.wr_y !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_pre: got en=%b (%0d,%0d) want en=1 (5,1)", bus.wr_en, bus.wr_x, bus.wr_y);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wr_en, bus.busy, bus.done, bus.clipped} !== 4'b0000 ||
        {bus.wr_x, bus.wr_y, bus.wr_data, bus.n_written} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_async: got flags=%b data=%h want 0000 0",
               {bus.wr_en, bus.busy, bus.done, bus.clipped},
               {bus.wr_x, bus.wr_y, bus.wr_data, bus.n_written});
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_t_piece("post_rst", 5, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.x     = 5'd0;
    bus.y     = 5'd0;
    bus.mask  = 16'd0;
    bus.color = 3'd0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_t_piece();
    test_clip_right();
    test_clip_bottom();
    test_empty_mask();
    test_erase();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
